counter_cmd_sequencer: RTL and testbench
========================================

COUNTER_CMD_SEQUENCER -- requirements
Module: counter_cmd_sequencer

Interface
REQ-001 Clock  input  1  single clock; all state changes on its rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 CmdValid  input  1  command present on CmdOp/CmdData.
REQ-004 CmdReady  output  1  sequencer can accept a command.
REQ-005 CmdOp  input  3  opcode: 0 NOP, 1 CLEAR, 2 INC, 3 DEC, 4 LOAD_L2R, 5 LOAD_R2L, 6 INC_N, 7 DEC_N.
REQ-006 CmdData  input  8  load byte (ops 4/5) or repeat count N (ops 6/7); ignored otherwise.
REQ-007 CmdAbort  input  1  terminate the running command.
REQ-008 DoReset, DoIncrement, DoDecrement, DoShiftL2R, DoShiftR2L  output  1 each  strobes to the downstream 8-bit counter.
REQ-009 CounterInMSB, CounterInLSB  output  1 each  serial data bits to the downstream counter.
REQ-010 Busy  output  1  command in progress.
REQ-011 CmdDone  output  1  one-cycle pulse on normal completion.

Function
REQ-012 The block SHALL have two states, IDLE and RUN, and SHALL hold an 8-bit remaining-strobe counter Rem and an 8-bit shift register Sh.
REQ-013 CmdReady SHALL equal (state==IDLE); Busy SHALL equal (state==RUN).
REQ-014 A command SHALL be accepted at a rising edge where CmdValid && CmdReady.
REQ-015 Strobe count N per op: NOP 0, CLEAR 1, INC 1, DEC 1, LOAD_L2R 8, LOAD_R2L 8, INC_N/DEC_N = CmdData (0..255).
REQ-016 On acceptance with N>=1: state<=RUN, Rem<=N, Sh<=CmdData. With N=0: state stays IDLE, no strobe, no CmdDone.
REQ-017 In RUN, exactly one Do* output SHALL be high, selected by the latched op: CLEAR->DoReset, INC/INC_N->DoIncrement, DEC/DEC_N->DoDecrement, LOAD_L2R->DoShiftL2R, LOAD_R2L->DoShiftR2L. In IDLE all Do* SHALL be 0.
REQ-018 Strobes SHALL appear in the N consecutive cycles immediately after the accepting edge (latency 1 cycle).
REQ-019 At each rising edge in RUN, Rem SHALL decrement; at the edge where Rem==1, state SHALL return to IDLE.
REQ-020 LOAD_L2R SHALL drive CounterInMSB = Sh[0] with Sh shifted right each strobe, so data bit 0 goes first; after 8 strobes the counter holds CmdData.
REQ-021 LOAD_R2L SHALL drive CounterInLSB = Sh[7] with Sh shifted left each strobe, so data bit 7 goes first; after 8 strobes the counter holds CmdData.
REQ-022 CounterInMSB and CounterInLSB SHALL be 0 whenever their shift strobe is not asserted.
REQ-023 CmdDone SHALL be high for exactly one cycle, in the cycle after the last strobe of a normally completed command.
REQ-024 CmdAbort high at a rising edge in RUN SHALL force IDLE at that edge: no further strobes, no CmdDone. CmdAbort SHALL have no effect in IDLE, including when CmdValid is high in the same cycle.
REQ-025 CmdValid/CmdOp/CmdData changes while CmdReady==0 SHALL be ignored. Back-to-back commands have a minimum gap of one strobe-free cycle between them.

Reset
REQ-026 Reset high SHALL immediately force state=IDLE, Rem=0, Sh=0, all Do* outputs 0, CounterInMSB=0, CounterInLSB=0, Busy=0 and CmdDone=0.
REQ-027 CmdReady SHALL be 1 while Reset is high. Reset asserted mid-command SHALL discard the command without issuing further strobes.
REQ-028 The first command SHALL be accepted at the first rising edge after Reset deasserts.

Verification
REQ-029 Accept LOAD_L2R, CmdData=8'hA5 -> DoShiftL2R high for 8 cycles; CounterInMSB sequence 1,0,1,0,0,1,0,1; a model counter reads 8'hA5; CmdDone pulses once.
REQ-030 Accept LOAD_R2L, CmdData=8'h3C -> DoShiftR2L high for 8 cycles; CounterInLSB sequence 0,0,1,1,1,1,0,0; a model counter reads 8'h3C.
REQ-031 Accept INC_N with N=3, then DEC_N with N=0 -> exactly 3 DoIncrement cycles; the second command produces no strobe and no CmdDone; CmdReady returns high.
REQ-032 Accept DEC_N with N=10, assert CmdAbort on the 4th strobe edge -> exactly 4 DoDecrement cycles, no CmdDone, IDLE at the next cycle.
REQ-033 Assert Reset asynchronously during the 5th strobe of LOAD_L2R -> all outputs 0 immediately; after release, CLEAR yields one DoReset cycle.
REQ-034 Hold CmdValid high continuously with CLEAR, INC, INC -> each command is accepted only when CmdReady=1, and strobes are separated by one idle cycle.

Source files
------------

// File: rtl/counter_cmd_sequencer_if.sv
// rtl/counter_cmd_sequencer_if.sv - command channel between a host and counter_cmd_sequencer
interface counter_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_abort;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// rtl/counter_cmd_sequencer.sv - turns commands into strobe/serial-bit sequences for a downstream 8-bit counter
module counter_cmd_sequencer (
  input  logic                   clk_i,
  input  logic                   rst_i,
  counter_cmd_sequencer_if.slave cmd_if,
  output logic                   do_reset_o,
  output logic                   do_increment_o,
  output logic                   do_decrement_o,
  output logic                   do_shift_l2r_o,
  output logic                   do_shift_r2l_o,
  output logic                   counter_in_msb_o,
  output logic                   counter_in_lsb_o,
  output logic                   busy_o,
  output logic                   cmd_done_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_CLEAR    = 3'd1;
  localparam logic [2:0] OP_INC      = 3'd2;
  localparam logic [2:0] OP_DEC      = 3'd3;
  localparam logic [2:0] OP_LOAD_L2R = 3'd4;
  localparam logic [2:0] OP_LOAD_R2L = 3'd5;
  localparam logic [2:0] OP_INC_N    = 3'd6;
  localparam logic [2:0] OP_DEC_N    = 3'd7;

  state_e     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] op_q, op_d;
  logic       done_q, done_d;
  logic [7:0] strobe_cnt;

  // Number of strobes the offered command would generate if accepted now.
  always_comb begin
    strobe_cnt = 8'd0;
    case (cmd_if.cmd_op)
      OP_CLEAR, OP_INC, OP_DEC: strobe_cnt = 8'd1;
      OP_LOAD_L2R, OP_LOAD_R2L: strobe_cnt = 8'd8;
      OP_INC_N, OP_DEC_N:       strobe_cnt = cmd_if.cmd_data;
      default:                  strobe_cnt = 8'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
      sh_q    <= 8'd0;
      op_q    <= OP_NOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    op_d    = op_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      // Zero-strobe commands are consumed without leaving IDLE.
      if (cmd_if.cmd_valid && (strobe_cnt != 8'd0)) begin
        state_d = ST_RUN;
        rem_d   = strobe_cnt;
        sh_d    = cmd_if.cmd_data;
        op_d    = cmd_if.cmd_op;
      end
    end else begin
      rem_d = rem_q - 8'd1;
      if (op_q == OP_LOAD_L2R) begin
        sh_d = {1'b0, sh_q[7:1]};
      end else if (op_q == OP_LOAD_R2L) begin
        sh_d = {sh_q[6:0], 1'b0};
      end
      // Abort wins over completion, so an abort on the last strobe suppresses CmdDone.
      if (cmd_if.cmd_abort) begin
        state_d = ST_IDLE;
        rem_d   = 8'd0;
        sh_d    = 8'd0;
      end else if (rem_q == 8'd1) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    cmd_if.cmd_ready = (state_q == ST_IDLE);
    busy_o           = (state_q == ST_RUN);
    cmd_done_o       = done_q;
    do_reset_o       = 1'b0;
    do_increment_o   = 1'b0;
    do_decrement_o   = 1'b0;
    do_shift_l2r_o   = 1'b0;
    do_shift_r2l_o   = 1'b0;
    if (state_q == ST_RUN) begin
      case (op_q)
        OP_CLEAR:           do_reset_o     = 1'b1;
        OP_INC, OP_INC_N:   do_increment_o = 1'b1;
        OP_DEC, OP_DEC_N:   do_decrement_o = 1'b1;
        OP_LOAD_L2R:        do_shift_l2r_o = 1'b1;
        OP_LOAD_R2L:        do_shift_r2l_o = 1'b1;
        default:            do_reset_o     = 1'b0;
      endcase
    end
    counter_in_msb_o = do_shift_l2r_o & sh_q[0];
    counter_in_lsb_o = do_shift_r2l_o & sh_q[7];
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb/tb_counter_cmd_sequencer.sv - self-checking bench with a cycle-schedule reference model
module tb_counter_cmd_sequencer;
  logic clk;
  logic rst;
  logic do_reset, do_inc, do_dec, do_l2r, do_r2l, in_msb, in_lsb, busy, done;

  counter_cmd_sequencer_if cif ();

  counter_cmd_sequencer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cmd_if           (cif.slave),
    .do_reset_o       (do_reset),
    .do_increment_o   (do_inc),
    .do_decrement_o   (do_dec),
    .do_shift_l2r_o   (do_l2r),
    .do_shift_r2l_o   (do_r2l),
    .counter_in_msb_o (in_msb),
    .counter_in_lsb_o (in_lsb),
    .busy_o           (busy),
    .cmd_done_o       (done)
  );

  // Expected-output record: {ready, busy, done, rst, inc, dec, l2r, r2l, msb, lsb}
  localparam logic [9:0] IDLE_REC = 10'b10_0000_0000;
  localparam logic [9:0] DONE_REC = 10'b10_1000_0000;

  logic [9:0] q[$];
  int ncmp, nerr;
  int cnt[6];
  int snap[6];
  logic [7:0] dcnt, msb_hist, lsb_hist;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Schedule the output of every future cycle of an accepted command.
  task automatic push_cmd(input logic [2:0] op, input logic [7:0] d);
    int n;
    logic [9:0] r;
    case (op)
      3'd0:             n = 0;
      3'd1, 3'd2, 3'd3: n = 1;
      3'd4, 3'd5:       n = 8;
      default:          n = int'(d);
    endcase
    for (int i = 0; i < n; i++) begin
      r = 10'b01_0000_0000;
      case (op)
        3'd1:       r[6] = 1'b1;
        3'd2, 3'd6: r[5] = 1'b1;
        3'd3, 3'd7: r[4] = 1'b1;
        3'd4: begin r[3] = 1'b1; r[1] = d[3'(i)];     end
        3'd5: begin r[2] = 1'b1; r[0] = d[3'(7 - i)]; end
        default: ;
      endcase
      q.push_back(r);
    end
    if (n > 0) q.push_back(DONE_REC);
  endtask

  task automatic model_loop();
    logic was_busy;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
      end else begin
        was_busy = (q.size() != 0) && q[0][8];
        if (q.size() != 0) void'(q.pop_front());
        if (was_busy && cif.cmd_abort) q.delete();
        else if (!was_busy && cif.cmd_valid) push_cmd(cif.cmd_op, cif.cmd_data);
      end
    end
  endtask

  task automatic monitor_loop();
    logic [9:0] act, exp;
    forever begin
      @(negedge clk);
      act = {cif.cmd_ready, busy, done, do_reset, do_inc, do_dec, do_l2r, do_r2l, in_msb, in_lsb};
      exp = (q.size() != 0) ? q[0] : IDLE_REC;
      ncmp++;
      if (act !== exp) begin
        nerr++;
        $display("FAIL cycle_outputs t=%0t got %b expected %b", $time, act, exp);
      end
      if (do_reset) begin cnt[0]++; dcnt = 8'd0; end
      if (do_inc)   begin cnt[1]++; dcnt = dcnt + 8'd1; end
      if (do_dec)   begin cnt[2]++; dcnt = dcnt - 8'd1; end
      if (do_l2r)   begin cnt[3]++; dcnt = {in_msb, dcnt[7:1]}; msb_hist = {msb_hist[6:0], in_msb}; end
      if (do_r2l)   begin cnt[4]++; dcnt = {dcnt[6:0], in_lsb}; lsb_hist = {lsb_hist[6:0], in_lsb}; end
      if (done)     cnt[5]++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a command until it is taken; returns the number of edges it took.
  task automatic send(input logic [2:0] op, input logic [7:0] d, input bit drop, output int t);
    logic rdy;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = d;
    t = 0;
    do begin
      @(negedge clk);
      rdy = cif.cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 400);
    if (!rdy) begin
      ncmp++;
      nerr++;
      $display("FAIL send_timeout: got ready=0 after %0d edges expected acceptance", t);
    end
    if (drop) cif.cmd_valid = 1'b0;
  endtask

  function automatic int delta(input int k);
    return cnt[k] - snap[k];
  endfunction

  initial begin
    int t;
    ncmp = 0; nerr = 0;
    for (int k = 0; k < 6; k++) begin cnt[k] = 0; snap[k] = 0; end
    dcnt = 8'd0; msb_hist = 8'd0; lsb_hist = 8'd0;
    rst = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_op = 3'd0; cif.cmd_data = 8'd0; cif.cmd_abort = 1'b0;
    fork
      model_loop();
      monitor_loop();
    join_none
    #1 rst = 1'b1;
    idle(3);
    chk("reset_ready", 32'(cif.cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    snap = cnt;
    send(3'd1, 8'd0, 1'b1, t);
    chk("first_accept_edges", 32'(t), 32'd1);
    idle(3);
    chk("clear_strobes", 32'(delta(0)), 32'd1);
    chk("clear_counter", 32'(dcnt), 32'h00);

    snap = cnt;
    send(3'd4, 8'hA5, 1'b1, t);
    idle(10);
    chk("l2r_strobes", 32'(delta(3)), 32'd8);
    chk("l2r_msb_seq", 32'(msb_hist), 32'b1010_0101);
    chk("l2r_counter", 32'(dcnt), 32'hA5);
    chk("l2r_done", 32'(delta(5)), 32'd1);

    snap = cnt;
    send(3'd5, 8'h3C, 1'b1, t);
    idle(10);
    chk("r2l_strobes", 32'(delta(4)), 32'd8);
    chk("r2l_lsb_seq", 32'(lsb_hist), 32'b0011_1100);
    chk("r2l_counter", 32'(dcnt), 32'h3C);

    snap = cnt;
    send(3'd6, 8'd3, 1'b1, t);
    send(3'd7, 8'd0, 1'b1, t);
    idle(6);
    chk("incn_strobes", 32'(delta(1)), 32'd3);
    chk("decn0_strobes", 32'(delta(2)), 32'd0);
    chk("incn_done_once", 32'(delta(5)), 32'd1);
    chk("incn_ready_back", 32'(cif.cmd_ready), 32'd1);

    snap = cnt;
    send(3'd7, 8'd10, 1'b1, t);
    idle(3);
    cif.cmd_abort = 1'b1;
    idle(1);
    cif.cmd_abort = 1'b0;
    chk("abort_idle_next", 32'(busy), 32'd0);
    idle(12);
    chk("abort_dec_strobes", 32'(delta(2)), 32'd4);
    chk("abort_no_done", 32'(delta(5)), 32'd0);

    snap = cnt;
    send(3'd4, 8'h5A, 1'b1, t);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        32'({cif.cmd_ready, busy, done, do_reset, do_inc, do_dec, do_l2r, do_r2l, in_msb, in_lsb}),
        32'(IDLE_REC));
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_mid_l2r_strobes", 32'(delta(3)), 32'd4);
    chk("reset_mid_no_done", 32'(delta(5)), 32'd0);
    snap = cnt;
    send(3'd1, 8'd0, 1'b1, t);
    idle(3);
    chk("post_reset_clear", 32'(delta(0)), 32'd1);

    snap = cnt;
    send(3'd1, 8'd0, 1'b0, t);
    send(3'd2, 8'd0, 1'b0, t);
    send(3'd2, 8'd0, 1'b1, t);
    idle(4);
    chk("held_valid_clear", 32'(delta(0)), 32'd1);
    chk("held_valid_inc", 32'(delta(1)), 32'd2);
    chk("held_valid_counter", 32'(dcnt), 32'd2);

    snap = cnt;
    cif.cmd_abort = 1'b1;
    send(3'd2, 8'd0, 1'b1, t);
    cif.cmd_abort = 1'b0;
    idle(3);
    chk("abort_in_idle_inc", 32'(delta(1)), 32'd1);
    chk("abort_in_idle_done", 32'(delta(5)), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      cif.cmd_valid = ($urandom_range(0, 9) < 6);
      cif.cmd_op    = 3'($urandom_range(0, 7));
      cif.cmd_data  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      cif.cmd_abort = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 399) == 0);
      idle(1);
    end
    cif.cmd_valid = 1'b0;
    cif.cmd_abort = 1'b0;
    rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
